// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses PLL reset, waits for a stable lock, then releases core reset.
module pll_lock_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 1048576,
   parameter int STABLE_CYCLES  = 4096,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       soft_reset,
   output logic       pll_rst,
   output logic       core_reset_n,
   output logic       running,
   output logic       timeout_err,
   output logic [7:0] relock_count
);
   localparam int MAX_AB = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAXC   = MAX_AB > STABLE_CYCLES ? MAX_AB : STABLE_CYCLES;
   localparam int CW     = $clog2(MAXC);
   typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
   state_t                 state, nxt;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   locked_s, tmo, lost;
   assign locked_s = sync[SYNC_STAGES-1];
   always_comb begin
      nxt = state;
      case (state)
         PLL_RST:   nxt = cnt == CW'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : PLL_RST;
         WAIT_LOCK: nxt = locked_s ? STABLE : cnt == CW'(LOCK_TIMEOUT - 1) ? PLL_RST : WAIT_LOCK;
         STABLE:    nxt = !locked_s ? WAIT_LOCK : cnt == CW'(STABLE_CYCLES - 1) ? RUN : STABLE;
         RUN:       nxt = locked_s ? RUN : PLL_RST;
         default:   nxt = PLL_RST;
      endcase
      if (soft_reset) nxt = PLL_RST;
      tmo  = state == WAIT_LOCK && !locked_s && cnt == CW'(LOCK_TIMEOUT - 1) && !soft_reset;
      lost = state == RUN && !locked_s && !soft_reset;
   end
   // core_reset_n drops on the same edge that leaves RUN, so it never overlaps pll_rst
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state        <= PLL_RST;
         cnt          <= '0;
         sync         <= '0;
         pll_rst      <= 1'b1;
         core_reset_n <= 1'b0;
         running      <= 1'b0;
         timeout_err  <= 1'b0;
         relock_count <= '0;
      end else begin
         state        <= nxt;
         cnt          <= (nxt != state || soft_reset) ? '0 : cnt + CW'(1);
         sync         <= {sync[SYNC_STAGES-2:0], pll_locked};
         pll_rst      <= nxt == PLL_RST;
         core_reset_n <= state == RUN && nxt == RUN;
         running      <= state == RUN && nxt == RUN;
         timeout_err  <= timeout_err | tmo;
         relock_count <= relock_count + 8'(lost && relock_count != 8'hff);
      end
   end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed checks of the PLL lock sequence with small parameters.
module tb_pll_lock_sequencer;
   logic       clk_74a = 1'b0, reset_n = 1'b0, pll_locked = 1'b0, soft_reset = 1'b0;
   logic       pll_rst, core_reset_n, running, timeout_err;
   logic [7:0] relock_count;
   int         checks = 0, failures = 0;
   logic       ok;
   always #5 clk_74a = ~clk_74a;
   pll_lock_sequencer #(
      .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(8), .SYNC_STAGES(2)
   ) dut (
      .clk_74a(clk_74a), .reset_n(reset_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
      .pll_rst(pll_rst), .core_reset_n(core_reset_n), .running(running),
      .timeout_err(timeout_err), .relock_count(relock_count)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_74a);
         #1;
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_pll_rst"}, pll_rst, 1);
      chk({tag, "_core_reset_n"}, core_reset_n, 0);
      chk({tag, "_running"}, running, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
      chk({tag, "_relock_count"}, relock_count, 0);
   endtask
   initial begin
      step(3);
      chk_reset("rst");
      // power-up: pll_rst for 4 cycles, then lock after 10 cycles
      reset_n = 1'b1;
      step(3);
      chk("t1_prst_c3", pll_rst, 1);
      step(1);
      chk("t1_prst_c4", pll_rst, 0);
      step(6);
      pll_locked = 1'b1;
      step(11);
      chk("t1_crn_early", core_reset_n, 0);
      chk("t1_run_early", running, 0);
      step(1);
      chk("t1_crn", core_reset_n, 1);
      chk("t1_run", running, 1);
      chk("t1_te", timeout_err, 0);
      // lock loss in RUN for 5 cycles
      pll_locked = 1'b0;
      step(2);
      chk("t3_crn_hold", core_reset_n, 1);
      step(1);
      chk("t3_crn_drop", core_reset_n, 0);
      chk("t3_prst_rise", pll_rst, 1);
      chk("t3_rc", relock_count, 1);
      step(2);
      pll_locked = 1'b1;
      step(1);
      chk("t3_prst_c3", pll_rst, 1);
      step(1);
      chk("t3_prst_fall", pll_rst, 0);
      step(9);
      chk("t3_crn_early", core_reset_n, 0);
      step(1);
      chk("t3_crn_back", core_reset_n, 1);
      chk("t3_run_back", running, 1);
      // soft reset, then a one-cycle glitch at stable count 6
      soft_reset = 1'b1;
      step(1);
      soft_reset = 1'b0;
      chk("t4_soft_prst", pll_rst, 1);
      chk("t4_soft_crn", core_reset_n, 0);
      chk("t4_soft_rc", relock_count, 1);
      step(4);
      chk("t4_prst_fall", pll_rst, 0);
      step(5);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(3);
      chk("t4_no_prst", pll_rst, 0);
      step(1);
      chk("t4_crn_nominal", core_reset_n, 0);
      step(7);
      chk("t4_crn_late", core_reset_n, 0);
      chk("t4_no_prst2", pll_rst, 0);
      step(1);
      chk("t4_crn_run", core_reset_n, 1);
      // soft reset coinciding with lock loss does not count
      pll_locked = 1'b0;
      step(2);
      soft_reset = 1'b1;
      step(1);
      soft_reset = 1'b0;
      chk("t5_rc_same", relock_count, 1);
      chk("t5_prst", pll_rst, 1);
      chk("t5_crn", core_reset_n, 0);
      ok = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         pll_locked = 1'b1;
         for (int k = 0; k < 100 && !running; k++) step(1);
         if (!running) ok = 1'b0;
         pll_locked = 1'b0;
         for (int k = 0; k < 10 && !pll_rst; k++) step(1);
         if (!pll_rst) ok = 1'b0;
         if (i == 253) chk("t5_rc_254", relock_count, 254);
         if (i == 254) chk("t5_rc_255", relock_count, 255);
      end
      chk("t5_rc_sat", relock_count, 255);
      chk("t5_loop_ok", ok, 1);
      chk("t5_te", timeout_err, 0);
      // asynchronous reset during STABLE
      pll_locked = 1'b1;
      step(7);
      chk("t6_stable_crn", core_reset_n, 0);
      chk("t6_stable_prst", pll_rst, 0);
      #2 reset_n = 1'b0;
      #1 chk_reset("t6_async");
      step(2);
      pll_locked = 1'b0;
      step(1);
      reset_n = 1'b1;
      // no lock: timeout retries every 68 cycles
      step(4);
      chk("t2_prst_fall", pll_rst, 0);
      step(63);
      chk("t2_prst_wait", pll_rst, 0);
      chk("t2_te_before", timeout_err, 0);
      step(1);
      chk("t2_prst_retry", pll_rst, 1);
      chk("t2_te", timeout_err, 1);
      chk("t2_rc", relock_count, 0);
      step(3);
      chk("t2_prst_hold", pll_rst, 1);
      step(1);
      chk("t2_prst_fall2", pll_rst, 0);
      step(63);
      chk("t2_prst_wait2", pll_rst, 0);
      step(1);
      chk("t2_prst_retry2", pll_rst, 1);
      chk("t2_te_sticky", timeout_err, 1);
      chk("t2_crn", core_reset_n, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
